// File: rtl/data_mem_if.sv
// data_mem_if: bridge between the load/store unit and a req/gnt/rvalid data memory port.
// A held core request is alignment-checked and lane-shifted, then issued as one word-aligned
// memory access with wait states. The pipeline stalls until a one-cycle o_done pulse.
// Misaligned requests complete without touching memory. Stalled handshakes end in a bus error.
module data_mem_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req,
    input  logic              i_wen,
    input  logic              i_ren,
    input  logic [2:0]        i_func3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_byte_en,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_misaligned,
    output logic              o_bus_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    // Wait-state counter sized to hold TIMEOUT. A TIMEOUT of 0 disables the bus-error path.
    localparam bit                TIMEOUT_EN = (TIMEOUT > 0);
    localparam int                CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RDWAIT,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                misaligned_q, misaligned_d;
    logic                bus_err_q, bus_err_d;

    logic                req_active;
    logic                is_write;
    logic                misaligned_req;
    logic [DATA_W-1:0]   shifted_wdata;
    logic                done;
    logic                unused_func3_bit;

    // The sign/unsigned bit of func3 only matters to load extraction, which is done downstream.
    assign unused_func3_bit = i_func3[2];

    // Decode the held core request: activity, direction, alignment and store-lane placement.
    always_comb begin
        req_active = i_req & (i_wen | i_ren);
        // A request with both enables set is treated as a store.
        is_write   = i_wen;
        unique case (i_func3[1:0])
            2'b00:   misaligned_req = 1'b0;
            2'b01:   misaligned_req = (i_addr[1:0] == 2'b11);
            default: misaligned_req = (i_addr[1:0] != 2'b00);
        endcase
        shifted_wdata = i_wdata << {i_addr[1:0], 3'b000};
    end

    // Next-state and next-register values of the access sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path leaves one unassigned
        // and no latch is inferred.
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = mem_we_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        misaligned_d  = 1'b0;
        bus_err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_active) begin
                    if (misaligned_req) begin
                        // Rejected without a memory access. The memory-side registers stay at 0.
                        state_d      = ST_DONE;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        mem_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = is_write ? i_byte_en : 4'b1111;
                        mem_wdata_d = shifted_wdata;
                        mem_we_d    = is_write;
                    end
                end
            end

            ST_REQ: begin
                if (i_mem_gnt) begin
                    // The read-data phase gets its own full wait budget.
                    cnt_d   = '0;
                    state_d = mem_we_q ? ST_DONE : ST_RDWAIT;
                end else if (TIMEOUT_EN && (cnt_q >= CNT_LAST)) begin
                    state_d   = ST_DONE;
                    bus_err_d = 1'b1;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RDWAIT: begin
                if (i_mem_rvalid) begin
                    rdata_d = i_mem_rdata;
                    state_d = ST_DONE;
                end else if (TIMEOUT_EN && (cnt_q >= CNT_LAST)) begin
                    state_d   = ST_DONE;
                    bus_err_d = 1'b1;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                mem_addr_d  = '0;
                mem_be_d    = '0;
                mem_wdata_d = '0;
                mem_we_d    = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values,
            // independent of statement order.
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Output drive.
    // The stall is gated by reset, so every output reads 0 while i_rstn is low.
    always_comb begin
        done         = (state_q == ST_DONE);
        o_done       = done;
        o_stall      = i_rstn & req_active & ~done;
        o_rdata      = rdata_q;
        o_misaligned = misaligned_q;
        o_bus_err    = bus_err_q;
        o_mem_req    = (state_q == ST_REQ);
        o_mem_we     = mem_we_q;
        o_mem_addr   = mem_addr_q;
        o_mem_be     = mem_be_q;
        o_mem_wdata  = mem_wdata_q;
    end

endmodule

// File: tb/tb_data_mem_if.sv
// tb_data_mem_if: directed and randomized accesses against a transaction-level model of data_mem_if.
module tb_data_mem_if;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic        i_clk;
    logic        i_rstn;
    logic        i_req;
    logic        i_wen;
    logic        i_ren;
    logic [2:0]  i_func3;
    logic [31:0] i_addr;
    logic [3:0]  i_byte_en;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_misaligned;
    logic        o_bus_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int          passed;
    int          total;
    logic [31:0] rdata_exp;

    data_mem_if #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req       (i_req),
        .i_wen       (i_wen),
        .i_ren       (i_ren),
        .i_func3     (i_func3),
        .i_addr      (i_addr),
        .i_byte_en   (i_byte_en),
        .i_wdata     (i_wdata),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_misaligned(o_misaligned),
        .o_bus_err   (o_bus_err),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_gnt   (i_mem_gnt),
        .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete access. The memory side answers with gnt on REQ cycle gnt_dly+1 and with
    // rvalid on RDWAIT cycle rv_dly+1. Expectations come from the access rules, not the RTL.
    task automatic access(input string tag, input logic wen, input logic ren,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd, input bit rv_with_gnt);
        bit          is_wr, mis, exp_err, granted, done_seen;
        int          g, w, exp_lat, exp_req, k, req_seen, rw_seen, stall_bad, hold_bad, flag_bad;
        logic [31:0] exp_addr, exp_wdata, cap_addr, cap_wdata;
        logic [3:0]  exp_be, cap_be;
        logic        cap_we, got_mis, got_err;

        is_wr = wen;
        mis   = ((f3[1:0] == 2'b01) && (addr[1:0] == 2'b11)) ||
                ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        g     = gnt_dly + 1;
        w     = rv_dly + 1;
        if (mis) begin
            exp_lat = 1; exp_err = 0; exp_req = 0;
        end else if (g > TIMEOUT) begin
            exp_lat = TIMEOUT + 1; exp_err = 1; exp_req = TIMEOUT;
        end else if (is_wr) begin
            exp_lat = g + 1; exp_err = 0; exp_req = g;
        end else if (w > TIMEOUT) begin
            exp_lat = g + TIMEOUT + 1; exp_err = 1; exp_req = g;
        end else begin
            exp_lat = g + w + 1; exp_err = 0; exp_req = g;
        end
        exp_addr  = {addr[31:2], 2'b00};
        exp_be    = is_wr ? be : 4'b1111;
        exp_wdata = wd << (8 * addr[1:0]);
        if (!mis && !is_wr && !exp_err) rdata_exp = rd;

        @(negedge i_clk);
        i_req = 1'b1; i_wen = wen; i_ren = ren; i_func3 = f3;
        i_addr = addr; i_byte_en = be; i_wdata = wd;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        #1;
        check({tag, "_stall_issue"}, o_stall, 1'b1);

        k = 0; req_seen = 0; rw_seen = 0; granted = 0; done_seen = 0;
        stall_bad = 0; hold_bad = 0; flag_bad = 0;
        cap_addr = '0; cap_be = '0; cap_wdata = '0; cap_we = 1'b0;
        got_mis = 1'b0; got_err = 1'b0;
        while (!done_seen && k < 60) begin
            @(negedge i_clk);
            k++;
            i_mem_gnt    = 1'b0;
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = $urandom;
            if (o_done) begin
                done_seen = 1;
                got_mis   = o_misaligned;
                got_err   = o_bus_err;
                check({tag, "_stall_done"}, o_stall, 1'b0);
                check({tag, "_req_in_done"}, o_mem_req, 1'b0);
                check({tag, "_rdata"}, o_rdata, rdata_exp);
            end else begin
                if (!o_stall) stall_bad++;
                if (o_misaligned || o_bus_err) flag_bad++;
                if (o_mem_req) begin
                    req_seen++;
                    if (req_seen == 1) begin
                        cap_addr = o_mem_addr; cap_be = o_mem_be;
                        cap_wdata = o_mem_wdata; cap_we = o_mem_we;
                    end else if (o_mem_addr !== cap_addr || o_mem_be !== cap_be ||
                                 o_mem_wdata !== cap_wdata || o_mem_we !== cap_we) begin
                        hold_bad++;
                    end
                    if (req_seen == g) begin
                        i_mem_gnt = 1'b1;
                        granted   = 1;
                        if (rv_with_gnt) begin
                            i_mem_rvalid = 1'b1;
                            i_mem_rdata  = ~rd;
                        end
                    end
                end else if (granted && !is_wr) begin
                    rw_seen++;
                    if (rw_seen == w) begin
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata  = rd;
                    end
                end
            end
        end
        i_req = 1'b0; i_wen = 1'b0; i_ren = 1'b0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;

        check({tag, "_done_seen"}, done_seen, 1'b1);
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_misaligned"}, got_mis, mis);
        check({tag, "_bus_err"}, got_err, exp_err);
        check({tag, "_req_cycles"}, req_seen, exp_req);
        check({tag, "_stall_held"}, stall_bad, 0);
        check({tag, "_flags_quiet"}, flag_bad, 0);
        if (!mis) begin
            check({tag, "_mem_addr"}, cap_addr, exp_addr);
            check({tag, "_mem_be"}, cap_be, exp_be);
            check({tag, "_mem_wdata"}, cap_wdata, exp_wdata);
            check({tag, "_mem_we"}, cap_we, is_wr);
            check({tag, "_mem_hold"}, hold_bad, 0);
        end
    endtask

    initial begin
        passed = 0; total = 0; rdata_exp = '0;
        i_rstn = 1'b0; i_req = 1'b0; i_wen = 1'b0; i_ren = 1'b0; i_func3 = 3'b000;
        i_addr = '0; i_byte_en = '0; i_wdata = '0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

        // Reset state.
        #2;
        check("rst_ctrl", {o_stall, o_done, o_misaligned, o_bus_err, o_mem_req, o_mem_we, o_mem_be}, '0);
        check("rst_addr", o_mem_addr, '0);
        check("rst_wdata", o_mem_wdata, '0);
        check("rst_rdata", o_rdata, '0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // SB with immediate grant.
        access("sb", 1, 0, 3'b000, 32'h0000_1002, 4'b0100, 32'h0000_00A5, 0, 0, '0, 0);
        // LW with grant after 3 wait cycles, rvalid 2 cycles later.
        access("lw_wait", 0, 1, 3'b010, 32'h0000_2000, 4'b0000, '0, 3, 1, 32'hDEAD_BEEF, 0);
        // Misaligned half and word.
        access("sh_mis", 1, 0, 3'b001, 32'h0000_1003, 4'b1000, 32'h0000_BEEF, 0, 0, '0, 0);
        access("lw_mis", 0, 1, 3'b010, 32'h0000_1001, 4'b0000, '0, 0, 0, 32'h5555_5555, 0);
        // Grant never arrives, then grant exactly on the expiry cycle.
        access("lw_gnt_to", 0, 1, 3'b010, 32'h0000_3000, 4'b0000, '0, NEVER, 0, 32'h7777_7777, 0);
        access("lw_gnt_edge", 0, 1, 3'b010, 32'h0000_3004, 4'b0000, '0, TIMEOUT - 1, 0, 32'h0BAD_F00D, 0);
        // rvalid alongside gnt is not taken as read data.
        access("lw_early_rv", 0, 1, 3'b010, 32'h0000_0040, 4'b0000, '0, 0, 1, 32'h1122_3344, 1);
        // rvalid never arrives: bus error, o_rdata keeps the previous value.
        access("lw_rv_to", 0, 1, 3'b010, 32'h0000_0044, 4'b0000, '0, 0, NEVER, 32'h9999_9999, 0);
        // Both enables: performed as a store.
        access("sw_both", 1, 1, 3'b010, 32'h0000_0104, 4'b1111, 32'h1234_5678, 0, 0, '0, 0);
        // Halfword at offset 2 and byte loads exercise lane shifting and the byte case.
        access("sh_hi", 1, 0, 3'b001, 32'h0000_0106, 4'b1100, 32'h0000_CAFE, 1, 0, '0, 0);
        access("lb_off3", 0, 1, 3'b000, 32'h0000_0207, 4'b1000, '0, 0, 2, 32'hA1B2_C3D4, 0);

        // i_req without either enable is ignored.
        @(negedge i_clk);
        i_req = 1'b1; i_wen = 1'b0; i_ren = 1'b0; i_addr = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("noen_quiet", {o_stall, o_mem_req, o_done}, '0);
        end
        i_req = 1'b0;

        // Reset during RDWAIT abandons the read; a late rvalid is ignored.
        @(negedge i_clk);
        i_req = 1'b1; i_ren = 1'b1; i_wen = 1'b0; i_func3 = 3'b010; i_addr = 32'h0000_4000;
        @(negedge i_clk);
        check("rstmid_req", o_mem_req, 1'b1);
        i_mem_gnt = 1'b1;
        @(negedge i_clk);
        i_mem_gnt = 1'b0;
        check("rstmid_rdwait", {o_mem_req, o_stall, o_done}, 3'b010);
        #2;
        i_rstn = 1'b0;
        #1;
        check("rstmid_ctrl", {o_stall, o_done, o_misaligned, o_bus_err, o_mem_req, o_mem_we, o_mem_be}, '0);
        check("rstmid_addr", o_mem_addr, '0);
        check("rstmid_rdata", o_rdata, '0);
        rdata_exp = '0;
        i_req = 1'b0; i_ren = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
        @(negedge i_clk);
        i_mem_rvalid = 1'b0;
        check("late_rv_rdata", o_rdata, '0);
        check("late_rv_idle", {o_done, o_mem_req, o_bus_err}, '0);
        @(negedge i_clk);
        check("late_rv_nodone", o_done, 1'b0);

        // Randomized accesses.
        for (int n = 0; n < 40; n++) begin
            int          op;
            logic [2:0]  f3;
            op = $urandom_range(0, 2);
            f3 = 3'($urandom_range(0, 2));
            access("rnd", (op != 0), (op != 1), f3, $urandom, 4'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
